riscv_hazard: RTL and testbench

Pipeline hazard and forwarding controller for the 5-stage RISC-V hart (IF/ID/EX/MA/WB). It tracks destination-register tags for instructions in EX, MA and WB. From those tags it produces per-source forwarding selects, load-use bubbles, branch flushes and memory-wait freezes. It is generalised over data width, register count and number of source operands, and replaces the hart's fixed "no bubbles" fetch control.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/riscv_fwd_match.sv | 48 ++++
 rtl/riscv_hazard.sv | 126 ++++++++++++
 tb/tb_riscv_hazard.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V hart hazard/forwarding controller:
// forwarding select encoding, pipeline tag record and register-index width helper.
package riscv_pkg;

    // Tags carry rd at a fixed maximum width so the struct is parameter-free.
    localparam int RD_W_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_MA = 2'd2,
        FWD_WB = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic                load;
        logic [RD_W_MAX-1:0] rd;
    } stage_tag_t;

    localparam stage_tag_t TAG_NONE = '{valid: 1'b0, we: 1'b0, load: 1'b0, rd: {RD_W_MAX{1'b0}}};

    function automatic int rega_f(input int regn);
        return (regn > 1) ? $clog2(regn) : 1;
    endfunction

endpackage

// File: rtl/riscv_fwd_match.sv
// Per-source priority match of one ID source register against the EX/MA/WB tags;
// returns the forwarding select and whether the match is an unresolved EX load.
module riscv_fwd_match
    import riscv_pkg::*;
#(
    parameter int REGA = 5
) (
    input  logic [REGA-1:0] rs_i,
    input  logic            used_i,
    input  stage_tag_t      ex_i,
    input  stage_tag_t      ma_i,
    input  stage_tag_t      wb_i,
    output fwd_sel_t        sel_o,
    output logic            load_hazard_o
);

    logic [RD_W_MAX-1:0] rs_ext_s;
    logic                hit_ex_s;
    logic                hit_ma_s;
    logic                hit_wb_s;
    logic                unused_s;

    assign rs_ext_s = RD_W_MAX'(rs_i);
    assign hit_ex_s = ex_i.valid & ex_i.we & (ex_i.rd == rs_ext_s);
    assign hit_ma_s = ma_i.valid & ma_i.we & (ma_i.rd == rs_ext_s);
    assign hit_wb_s = wb_i.valid & wb_i.we & (wb_i.rd == rs_ext_s);
    // Only the EX stage's load flag matters: MA data is valid once mem_ready is high.
    assign unused_s = ^{ma_i.load, wb_i.load};

    // Youngest-first priority search; x0 and unread operands always come from the regfile.
    always_comb begin
        sel_o         = FWD_RF;
        load_hazard_o = 1'b0;
        if (!used_i || (rs_i == {REGA{1'b0}})) begin
            sel_o = FWD_RF;
        end else if (hit_ex_s) begin
            sel_o         = FWD_EX;
            load_hazard_o = ex_i.load;
        end else if (hit_ma_s) begin
            sel_o = FWD_MA;
        end else if (hit_wb_s) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/riscv_hazard.sv
// Hazard and forwarding controller for the 5-stage hart: EX/MA/WB destination tags,
// per-source forwarding selects, load-use bubbles, branch flushes and memory-wait freezes.
module riscv_hazard
    import riscv_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int REGN = 32,
    parameter  int NSRC = 2,
    localparam int REGA = rega_f(REGN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NSRC-1:0][REGA-1:0] id_rs,
    input  logic [NSRC-1:0]           id_rs_used,
    input  logic [REGA-1:0]           id_rd,
    input  logic                      id_we,
    input  logic                      id_load,
    input  logic                      branch_taken,
    input  logic                      mem_ready,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      bubble_ex,
    output logic                      flush_id,
    output logic                      freeze,
    output logic [NSRC-1:0][1:0]      fwd_sel,
    output logic [XLEN-1:0]           stall_cnt
);

    stage_tag_t      ex_q, ex_d;
    stage_tag_t      ma_q, ma_d;
    stage_tag_t      wb_q, wb_d;
    stage_tag_t      id_tag_s;
    logic [XLEN-1:0] cnt_q, cnt_d;

    logic [NSRC-1:0] hz_s;
    fwd_sel_t        sel_s [NSRC];
    logic            load_use_s;
    logic            freeze_s;
    logic            stall_s;
    logic            bubble_s;
    logic            flush_s;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        riscv_fwd_match #(.REGA(REGA)) u_match (
            .rs_i          (id_rs[g]),
            .used_i        (id_rs_used[g]),
            .ex_i          (ex_q),
            .ma_i          (ma_q),
            .wb_i          (wb_q),
            .sel_o         (sel_s[g]),
            .load_hazard_o (hz_s[g])
        );
        assign fwd_sel[g] = sel_s[g];
    end

    // A write to x0 enters the pipeline as a non-writer so it can never forward.
    assign id_tag_s = '{valid: id_valid,
                        we:    id_we & (id_rd != {REGA{1'b0}}),
                        load:  id_load,
                        rd:    RD_W_MAX'(id_rd)};

    assign load_use_s = |hz_s;
    assign freeze_s   = ma_q.valid & ~mem_ready;

    // Priority: memory freeze, then taken branch, then load-use stall.
    always_comb begin
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        flush_s  = 1'b0;
        if (freeze_s) begin
            stall_s = 1'b1;
        end else if (branch_taken) begin
            bubble_s = 1'b1;
            flush_s  = 1'b1;
        end else if (load_use_s) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign stall_if  = stall_s;
    assign stall_id  = stall_s;
    assign bubble_ex = bubble_s;
    assign flush_id  = flush_s;
    assign freeze    = freeze_s;
    assign stall_cnt = cnt_q;

    // Tag shift and stall-cycle counter next state; a freeze holds every tag in place.
    always_comb begin
        ex_d  = ex_q;
        ma_d  = ma_q;
        wb_d  = wb_q;
        cnt_d = cnt_q;
        if (stall_s) begin
            cnt_d = cnt_q + XLEN'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (!freeze_s) begin
            wb_d = ma_q;
            ma_d = ex_q;
            ex_d = bubble_s ? TAG_NONE : id_tag_s;
        end else begin
            ex_d = ex_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= TAG_NONE;
            ma_q  <= TAG_NONE;
            wb_q  <= TAG_NONE;
            cnt_q <= {XLEN{1'b0}};
        end else begin
            ex_q  <= ex_d;
            ma_q  <= ma_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_riscv_hazard.sv
// Self-checking bench for riscv_hazard: directed pipeline scenarios followed by random
// traffic, checked against an instruction-history reference model.
module tb_riscv_hazard;

    localparam int XLEN = 32;
    localparam int REGN = 32;
    localparam int NSRC = 2;
    localparam int REGA = 5;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      id_valid;
    logic [NSRC-1:0][REGA-1:0] id_rs;
    logic [NSRC-1:0]           id_rs_used;
    logic [REGA-1:0]           id_rd;
    logic                      id_we;
    logic                      id_load;
    logic                      branch_taken;
    logic                      mem_ready;
    logic                      stall_if;
    logic                      stall_id;
    logic                      bubble_ex;
    logic                      flush_id;
    logic                      freeze;
    logic [NSRC-1:0][1:0]      fwd_sel;
    logic [XLEN-1:0]           stall_cnt;

    always #5 clk = ~clk;

    riscv_hazard #(.XLEN(XLEN), .REGN(REGN), .NSRC(NSRC)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_rd        (id_rd),
        .id_we        (id_we),
        .id_load      (id_load),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex),
        .flush_id     (flush_id),
        .freeze       (freeze),
        .fwd_sel      (fwd_sel),
        .stall_cnt    (stall_cnt)
    );

    // Reference model: the last three issued instructions, age 1 = EX, 2 = MA, 3 = WB.
    bit              m_v  [4];
    bit              m_w  [4];
    bit              m_l  [4];
    int              m_rd [4];
    logic [XLEN-1:0] m_cnt;

    logic            cap_sif, cap_sid, cap_bub, cap_fl, cap_fz;
    logic [1:0]      cap_fwd [NSRC];
    logic [XLEN-1:0] cap_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                          input int rd, input bit we, input bit ld);
        id_valid   = v;
        id_rs[0]   = REGA'(rs0);
        id_rs[1]   = REGA'(rs1);
        id_rs_used = used;
        id_rd      = REGA'(rd);
        id_we      = we;
        id_load    = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    endtask

    // One cycle: predict, compare combinational outputs mid-cycle, clock, advance model.
    task automatic step(input bit do_chk);
        int e_sel [NSRC];
        bit hz_src [NSRC];
        bit hz_any, fz, e_stall, e_bub, e_fl, found;
        #1;
        hz_any = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            e_sel[s]  = 0;
            hz_src[s] = 1'b0;
            found     = 1'b0;
            if (id_rs_used[s] && (int'(id_rs[s]) != 0)) begin
                for (int k = 1; k <= 3; k++) begin
                    if (!found && m_v[k] && m_w[k] && (m_rd[k] == int'(id_rs[s]))) begin
                        found     = 1'b1;
                        e_sel[s]  = k;
                        hz_src[s] = (k == 1) && m_l[1];
                    end
                end
            end
            hz_any |= hz_src[s];
        end
        fz      = m_v[2] && !mem_ready;
        e_stall = fz || (hz_any && !branch_taken);
        e_bub   = !fz && (branch_taken || hz_any);
        e_fl    = !fz && branch_taken;

        cap_sif = stall_if;
        cap_sid = stall_id;
        cap_bub = bubble_ex;
        cap_fl  = flush_id;
        cap_fz  = freeze;
        cap_cnt = stall_cnt;
        for (int s = 0; s < NSRC; s++) cap_fwd[s] = fwd_sel[s];

        if (do_chk) begin
            chk("stall_if", {31'd0, stall_if}, {31'd0, e_stall});
            chk("stall_id", {31'd0, stall_id}, {31'd0, e_stall});
            chk("bubble_ex", {31'd0, bubble_ex}, {31'd0, e_bub});
            chk("flush_id", {31'd0, flush_id}, {31'd0, e_fl});
            chk("freeze", {31'd0, freeze}, {31'd0, fz});
            chk("stall_cnt", stall_cnt, m_cnt);
            for (int s = 0; s < NSRC; s++) begin
                if (!hz_src[s]) chk($sformatf("fwd_sel[%0d]", s), {30'd0, fwd_sel[s]}, e_sel[s]);
            end
        end

        @(posedge clk);
        if (rst) begin
            for (int k = 1; k <= 3; k++) m_v[k] = 1'b0;
            m_cnt = '0;
        end else begin
            if (e_stall) m_cnt = m_cnt + 1;
            if (!fz) begin
                for (int k = 3; k >= 2; k--) begin
                    m_v[k] = m_v[k-1]; m_w[k] = m_w[k-1]; m_l[k] = m_l[k-1]; m_rd[k] = m_rd[k-1];
                end
                m_v[1]  = e_bub ? 1'b0 : id_valid;
                m_w[1]  = id_we && (id_rd != '0);
                m_l[1]  = id_load;
                m_rd[1] = int'(id_rd);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_v[k] = 1'b0; m_w[k] = 1'b0; m_l[k] = 1'b0; m_rd[k] = 0;
        end
        m_cnt        = '0;
        rst          = 1'b1;
        branch_taken = 1'b0;
        mem_ready    = 1'b1;
        nop();
        @(negedge clk);
        step(1'b0);
        step(1'b1);
        rst = 1'b0;
        step(1'b1);
        chk("reset fz", {31'd0, cap_fz}, 32'd0);
        chk("reset cnt", cap_cnt, 32'd0);

        // addi x1 ; add x2,x1,x1
        set_id(1'b1, 0, 0, 2'b01, 1, 1'b1, 1'b0); step(1'b1);
        set_id(1'b1, 1, 1, 2'b11, 2, 1'b1, 1'b0); step(1'b1);
        chk("tp1 fwd0", {30'd0, cap_fwd[0]}, 32'd1);
        chk("tp1 fwd1", {30'd0, cap_fwd[1]}, 32'd1);
        chk("tp1 stall", {31'd0, cap_sid}, 32'd0);
        chk("tp1 cnt", cap_cnt, 32'd0);

        // lw x5 ; add x6,x5,x0 (held one cycle)
        set_id(1'b1, 1, 0, 2'b01, 5, 1'b1, 1'b1); step(1'b1);
        set_id(1'b1, 5, 0, 2'b11, 6, 1'b1, 1'b0); step(1'b1);
        chk("tp2 stall_if", {31'd0, cap_sif}, 32'd1);
        chk("tp2 bubble", {31'd0, cap_bub}, 32'd1);
        step(1'b1);
        chk("tp2 fwd0", {30'd0, cap_fwd[0]}, 32'd2);
        chk("tp2 fwd1", {30'd0, cap_fwd[1]}, 32'd0);
        chk("tp2 stall", {31'd0, cap_sid}, 32'd0);
        chk("tp2 cnt", cap_cnt, 32'd1);

        // write x0 ; read x0
        set_id(1'b1, 0, 0, 2'b00, 0, 1'b1, 1'b0); step(1'b1);
        set_id(1'b1, 0, 0, 2'b11, 3, 1'b1, 1'b0); step(1'b1);
        chk("tp3 fwd0", {30'd0, cap_fwd[0]}, 32'd0);
        chk("tp3 stall", {31'd0, cap_sid}, 32'd0);

        // lw x7 ; load-use reader with a taken branch in the same cycle
        set_id(1'b1, 0, 0, 2'b00, 7, 1'b1, 1'b1); step(1'b1);
        set_id(1'b1, 7, 7, 2'b11, 9, 1'b1, 1'b0); branch_taken = 1'b1; step(1'b1);
        chk("tp4 flush", {31'd0, cap_fl}, 32'd1);
        chk("tp4 bubble", {31'd0, cap_bub}, 32'd1);
        chk("tp4 stall_if", {31'd0, cap_sif}, 32'd0);
        branch_taken = 1'b0;
        nop(); step(1'b1);
        chk("tp4 cnt", cap_cnt, 32'd1);

        // lw x8 reaches MA, then three memory-wait cycles
        set_id(1'b1, 0, 0, 2'b00, 8, 1'b1, 1'b1); step(1'b1);
        nop(); step(1'b1);
        set_id(1'b1, 8, 0, 2'b01, 10, 1'b1, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            chk("tp5 freeze", {31'd0, cap_fz}, 32'd1);
            chk("tp5 fwd0", {30'd0, cap_fwd[0]}, 32'd2);
        end
        mem_ready = 1'b1; step(1'b1);
        chk("tp5 resume", {31'd0, cap_fz}, 32'd0);
        chk("tp5 cnt", cap_cnt, 32'd4);

        // reset pulse during a freeze
        set_id(1'b1, 0, 0, 2'b00, 11, 1'b1, 1'b1); step(1'b1);
        nop(); step(1'b1);
        mem_ready = 1'b0; step(1'b1);
        chk("tp6 freeze", {31'd0, cap_fz}, 32'd1);
        rst = 1'b1; step(1'b1);
        rst = 1'b0; mem_ready = 1'b1; step(1'b1);
        chk("tp6 fz", {31'd0, cap_fz}, 32'd0);
        chk("tp6 bub", {31'd0, cap_bub}, 32'd0);
        chk("tp6 cnt", cap_cnt, 32'd0);
        set_id(1'b1, 11, 0, 2'b01, 12, 1'b1, 1'b0); step(1'b1);
        chk("tp6 fwd0", {30'd0, cap_fwd[0]}, 32'd0);

        // random traffic over a small register window to provoke matches
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 63) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            mem_ready    = ($urandom_range(0, 3) != 0);
            set_id($urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            step(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
